// File: rtl/bram_arb_pkg.sv
// Shared helpers for the BRAM arbiter: address width, one-hot decode and the
// rotate/priority functions used by the round-robin arbiters (up to 8 requesters).
package bram_arb_pkg;

    localparam int MAXREQ   = 8;
    localparam int IDXW     = 3;
    localparam int IDXW1    = IDXW + 1;
    localparam int DEF_SIZE = 256;
    localparam int AW       = $clog2(DEF_SIZE);

    function automatic int addr_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    function automatic logic [IDXW-1:0] onehot_to_idx(input logic [MAXREQ-1:0] oh);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAXREQ; i++) begin
            if (oh[i]) idx = idx | IDXW'(i);
        end
        return idx;
    endfunction

    // Bit i of the result is bit (i + amt) mod n of v; bits at or above n read as 0.
    function automatic logic [MAXREQ-1:0] rotate_right(input logic [MAXREQ-1:0] v,
                                                       input logic [IDXW-1:0]   amt,
                                                       input logic [IDXW:0]     n);
        logic [MAXREQ-1:0] r;
        logic [IDXW:0]     k;
        r = '0;
        for (int i = 0; i < MAXREQ; i++) begin
            k = IDXW1'(i) + {1'b0, amt};
            if (k >= n) k = k - n;
            if (IDXW1'(i) < n) r[i] = v[k[IDXW-1:0]];
        end
        return r;
    endfunction

    function automatic logic [IDXW-1:0] first_set(input logic [MAXREQ-1:0] v);
        logic [IDXW-1:0] idx;
        idx = '0;
        for (int i = MAXREQ - 1; i >= 0; i--) begin
            if (v[i]) idx = IDXW'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// advances the pointer past the grantee; the pointer holds when nobody requests.
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         gnt_valid
);

    localparam logic [IDXW:0] NW = IDXW1'(N);

    logic [IDXW-1:0]   ptr;
    logic [IDXW-1:0]   ptr_next;
    logic [IDXW-1:0]   off;
    logic [IDXW-1:0]   idx;
    logic [IDXW:0]     sum;
    logic [MAXREQ-1:0] req_ext;
    logic [MAXREQ-1:0] rot;
    logic [MAXREQ-1:0] gnt_ext;

    // Rotate so the pointer sits at bit 0, pick the lowest set bit, then map back.
    always_comb begin
        req_ext        = '0;
        req_ext[N-1:0] = req;
        rot            = rotate_right(req_ext, ptr, NW);
        off            = first_set(rot);
        sum            = {1'b0, ptr} + {1'b0, off};
        if (sum >= NW) sum = sum - NW;
        gnt_valid      = |req;
        gnt_ext        = '0;
        if (gnt_valid) gnt_ext[sum[IDXW-1:0]] = 1'b1;
        gnt            = gnt_ext[N-1:0];
        idx            = onehot_to_idx(gnt_ext);
        ptr_next       = ptr;
        if (gnt_valid) ptr_next = (idx == IDXW'(N - 1)) ? '0 : idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) ptr <= '0;
        else       ptr <= ptr_next;
    end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one dual-port BRAM between NREQ requesters: writes arbitrate for port A,
// reads for port B, and a same-cycle same-address collision bypasses the write data.
module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter  int WID  = 32,
    parameter  int SIZE = 256,
    parameter  int NREQ = 2,
    localparam int AW   = addr_width(SIZE)
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ-1:0]          req_we,
    input  logic [NREQ-1:0][AW-1:0]  req_addr,
    input  logic [NREQ-1:0][WID-1:0] req_wdata,
    output logic [NREQ-1:0]          req_ready,
    output logic [NREQ-1:0]          resp_valid,
    output logic [WID-1:0]           resp_data,
    output logic                     ena,
    output logic                     enb,
    output logic                     wea,
    output logic [AW-1:0]            addra,
    output logic [AW-1:0]            addrb,
    output logic [WID-1:0]           dina,
    input  logic [WID-1:0]           doutb
);

    logic [NREQ-1:0] wcand;
    logic [NREQ-1:0] rcand;
    logic [NREQ-1:0] wgnt;
    logic [NREQ-1:0] rgnt;
    logic            wvalid;
    logic            rvalid;
    logic            collide;
    logic            bypass;
    logic [WID-1:0]  byp_data;

    // Candidates are masked during reset so nothing is granted or driven to the BRAM.
    assign wcand = rstn ? (req_valid & req_we)  : '0;
    assign rcand = rstn ? (req_valid & ~req_we) : '0;

    rr_arbiter #(.N(NREQ)) u_warb (
        .clk       (clk),
        .rstn      (rstn),
        .req       (wcand),
        .gnt       (wgnt),
        .gnt_valid (wvalid)
    );

    rr_arbiter #(.N(NREQ)) u_rarb (
        .clk       (clk),
        .rstn      (rstn),
        .req       (rcand),
        .gnt       (rgnt),
        .gnt_valid (rvalid)
    );

    always_comb begin
        ena   = wvalid;
        wea   = wvalid;
        enb   = rvalid;
        addra = '0;
        addrb = '0;
        dina  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (wgnt[i]) begin
                addra = req_addr[i];
                dina  = req_wdata[i];
            end
            if (rgnt[i]) addrb = req_addr[i];
        end
    end

    assign req_ready = wgnt | rgnt;
    assign collide   = wvalid & rvalid & (addra == addrb);

    // The BRAM reads old data on a collision, so the write value is held for the response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_valid <= '0;
            bypass     <= 1'b0;
            byp_data   <= '0;
        end else begin
            resp_valid <= rgnt;
            bypass     <= collide;
            if (collide) byp_data <= dina;
        end
    end

    assign resp_data = (|resp_valid) ? (bypass ? byp_data : doutb) : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter with a behavioural read-first dual-port BRAM.
module tb_bram_arbiter;

    localparam int WID  = 32;
    localparam int SIZE = 256;
    localparam int NREQ = 2;
    localparam int AW   = 8;

    logic                     clk;
    logic                     rstn;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_we;
    logic [NREQ-1:0][AW-1:0]  req_addr;
    logic [NREQ-1:0][WID-1:0] req_wdata;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ-1:0]          resp_valid;
    logic [WID-1:0]           resp_data;
    logic                     ena, enb, wea;
    logic [AW-1:0]            addra, addrb;
    logic [WID-1:0]           dina;
    logic [WID-1:0]           doutb;

    logic [WID-1:0] mem [SIZE];

    typedef struct {
        logic [NREQ-1:0] who;
        logic [WID-1:0]  data;
        int              due;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    bram_arbiter #(.WID(WID), .SIZE(SIZE), .NREQ(NREQ)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .ena        (ena),
        .enb        (enb),
        .wea        (wea),
        .addra      (addra),
        .addrb      (addrb),
        .dina       (dina),
        .doutb      (doutb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc++;
        if (ena && wea) mem[addra] <= dina;
        if (enb) doutb <= mem[addrb];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] vld, input logic [1:0] we,
                                 input logic [7:0] a0, input logic [7:0] a1,
                                 input logic [31:0] d0, input logic [31:0] d1);
        req_valid    = vld;
        req_we       = we;
        req_addr[0]  = a0;
        req_addr[1]  = a1;
        req_wdata[0] = d0;
        req_wdata[1] = d1;
    endtask

    task automatic pushRead(input logic [1:0] who, input logic [31:0] data);
        sb.push_back('{who, data, cyc + 1});
    endtask

    task automatic idle();
        applyStimulus(2'b00, 2'b00, 8'd0, 8'd0, 32'd0, 32'd0);
    endtask

    // Monitor: a response is due exactly one cycle after its read grant.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            cur = sb.pop_front();
            checkOutput("resp_valid", 32'(resp_valid), 32'(cur.who));
            checkOutput("resp_data", resp_data, cur.data);
        end else if (resp_valid !== 2'b00) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_resp: got valid=%b data=%h expected none", resp_valid, resp_data);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < SIZE; i++) mem[i] = '0;
        mem[7] = 32'h0000_0077;
        rstn = 1'b0;
        applyStimulus(2'b11, 2'b11, 8'd1, 8'd2, 32'h1, 32'h2);
        #1;
        checkOutput("rst_ready", 32'(req_ready), 32'h0);
        checkOutput("rst_ena", 32'(ena), 32'h0);
        checkOutput("rst_wea", 32'(wea), 32'h0);
        checkOutput("rst_enb", 32'(enb), 32'h0);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("rst_resp_data", resp_data, 32'h0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        $display("[TB] write contention");
        applyStimulus(2'b11, 2'b11, 8'd1, 8'd2, 32'h1111_0001, 32'h2222_0002);
        for (int k = 0; k < 4; k++) begin
            #1;
            checkOutput("cont_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            checkOutput("cont_ena", 32'(ena), 32'h1);
            checkOutput("cont_addra", 32'(addra), (k % 2 == 0) ? 32'd1 : 32'd2);
            @(negedge clk);
        end
        checkOutput("cont_mem1", mem[1], 32'h1111_0001);
        checkOutput("cont_mem2", mem[2], 32'h2222_0002);

        $display("[TB] single write then read");
        applyStimulus(2'b01, 2'b01, 8'd5, 8'd0, 32'hDEAD_BEEF, 32'h0);
        #1;
        checkOutput("wr_ready", 32'(req_ready), 32'h1);
        checkOutput("wr_wea", 32'(wea), 32'h1);
        checkOutput("wr_addra", 32'(addra), 32'd5);
        checkOutput("wr_dina", dina, 32'hDEAD_BEEF);
        @(negedge clk);
        applyStimulus(2'b01, 2'b00, 8'd5, 8'd0, 32'h0, 32'h0);
        #1;
        checkOutput("rd_ready", 32'(req_ready), 32'h1);
        checkOutput("rd_enb", 32'(enb), 32'h1);
        checkOutput("rd_ena", 32'(ena), 32'h0);
        checkOutput("rd_addrb", 32'(addrb), 32'd5);
        pushRead(2'b01, 32'hDEAD_BEEF);
        @(negedge clk);
        idle();
        @(negedge clk);

        $display("[TB] parallel ports");
        applyStimulus(2'b11, 2'b01, 8'd3, 8'd7, 32'h11, 32'h0);
        #1;
        checkOutput("par_ready", 32'(req_ready), 32'h3);
        pushRead(2'b10, 32'h77);
        @(negedge clk);
        idle();
        @(negedge clk);

        $display("[TB] collision bypass");
        applyStimulus(2'b11, 2'b01, 8'd9, 8'd9, 32'hABCD_0123, 32'h0);
        #1;
        checkOutput("byp_ready", 32'(req_ready), 32'h3);
        checkOutput("byp_addrb", 32'(addrb), 32'd9);
        pushRead(2'b10, 32'hABCD_0123);
        @(negedge clk);
        applyStimulus(2'b10, 2'b00, 8'd0, 8'd9, 32'h0, 32'h0);
        #1;
        checkOutput("raw_ready", 32'(req_ready), 32'h2);
        pushRead(2'b10, 32'hABCD_0123);
        @(negedge clk);

        $display("[TB] idle");
        idle();
        #1;
        checkOutput("idle_ena", 32'(ena), 32'h0);
        checkOutput("idle_enb", 32'(enb), 32'h0);
        checkOutput("idle_wea", 32'(wea), 32'h0);
        checkOutput("idle_addra", 32'(addra), 32'h0);
        checkOutput("idle_addrb", 32'(addrb), 32'h0);
        checkOutput("idle_dina", dina, 32'h0);
        @(negedge clk);
        #1;
        checkOutput("idle_resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("idle_resp_data", resp_data, 32'h0);
        @(negedge clk);
        applyStimulus(2'b11, 2'b11, 8'd20, 8'd21, 32'hA0, 32'hA1);
        #1;
        checkOutput("idle_wptr_kept", 32'(req_ready), 32'h2);
        @(negedge clk);
        applyStimulus(2'b11, 2'b00, 8'd1, 8'd2, 32'h0, 32'h0);
        #1;
        checkOutput("idle_rptr_kept", 32'(req_ready), 32'h1);
        pushRead(2'b01, 32'h1111_0001);
        @(negedge clk);
        applyStimulus(2'b10, 2'b00, 8'd1, 8'd2, 32'h0, 32'h0);
        #1;
        checkOutput("rd_rr_ready", 32'(req_ready), 32'h2);
        pushRead(2'b10, 32'h2222_0002);
        @(negedge clk);

        $display("[TB] reset mid-operation");
        applyStimulus(2'b11, 2'b01, 8'd40, 8'd7, 32'h40, 32'h0);
        #1;
        checkOutput("prerst_ready", 32'(req_ready), 32'h3);
        @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checkOutput("midrst_resp_valid", 32'(resp_valid), 32'h0);
        checkOutput("midrst_resp_data", resp_data, 32'h0);
        checkOutput("midrst_ready", 32'(req_ready), 32'h0);
        checkOutput("midrst_ena", 32'(ena), 32'h0);
        checkOutput("midrst_enb", 32'(enb), 32'h0);
        #1;
        rstn = 1'b1;
        @(negedge clk);
        applyStimulus(2'b11, 2'b11, 8'd50, 8'd51, 32'h50, 32'h51);
        #1;
        checkOutput("postrst_wr_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        applyStimulus(2'b11, 2'b00, 8'd7, 8'd7, 32'h0, 32'h0);
        #1;
        checkOutput("postrst_rd_ready", 32'(req_ready), 32'h1);
        pushRead(2'b01, 32'h77);
        @(negedge clk);
        idle();

        for (int k = 0; k < 8 && sb.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Shares one DualPortBram between NREQ requesters. Write requests compete round-robin for BRAM port A and read requests, independently, for port B, so one write and one read can be granted in the same cycle. Read data returns one cycle after grant, tagged to the requester. A same-address write/read collision in one cycle is bypassed so the read sees the new data. The block sits between client units (cache refill, store path, debug) and the BRAM instance.

## Interface
- WID, 32, data width; must match the BRAM.
- SIZE, 256, BRAM depth in words; AW = $clog2(SIZE).
- NREQ, 2, number of requesters; legal range 2..8.

- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  [NREQ]  request present
- req_we  in  [NREQ]  1 = write, 0 = read
- req_addr  in  [NREQ][AW]  word address
- req_wdata  in  [NREQ][WID]  write data
- req_ready  out  [NREQ]  request granted this cycle (combinational)
- resp_valid  out  [NREQ]  read data valid for that requester
- resp_data  out  WID  read data, shared by all requesters
- ena, enb, wea  out  1  BRAM enables and write enable
- addra, addrb  out  AW  BRAM addresses
- dina  out  WID  BRAM write data
- doutb  in  WID  BRAM read data (registered, 1-cycle)

## Operation
- Write candidates are requesters with req_valid & req_we. Read candidates are requesters with req_valid & ~req_we.
- Each class has its own round-robin pointer (wptr, rptr). The grant goes to the first candidate at or after the pointer, wrapping from NREQ-1 to 0.
- After a grant, that class's pointer becomes grantee+1 mod NREQ. The pointer is unchanged when the class has no candidate.
- Write grant i: req_ready[i]=1; ena=wea=1; addra=req_addr[i]; dina=req_wdata[i].
- Read grant j: req_ready[j]=1; enb=1; addrb=req_addr[j].
- When no candidate exists: ena=wea=enb=0; addra, addrb and dina are 0.
- A requester holds valid, we, addr and wdata stable until it sees ready. A request is consumed on a cycle with valid & ready.
- Response: the registered read grant one-hot is driven as resp_valid in the next cycle. resp_data = doutb, or the bypass value if bypass was captured. resp_data = 0 when no resp_valid bit is set.
- Bypass: if a write and a read are granted in the same cycle with addra == addrb, capture dina and set a bypass flag. The next cycle's resp_data is that captured value, not doutb.
- A read granted in the cycle after a write to the same address needs no bypass, because the BRAM already holds the new value.
- The block applies no ordering across classes beyond this. A requester that must see its own write issues the read after its write is acknowledged.

## Timing
- Grant and req_ready are combinational from req_valid/req_we and the pointers, in cycle T. The BRAM is driven in T. resp_valid and resp_data appear in T+1.
- Throughput is 1 write + 1 read per cycle. Any single requester that stays valid is granted within NREQ cycles.
- Reset (asynchronous, rstn=0) clears: wptr=rptr=0, resp_valid=0, bypass flag=0, resp_data=0.
- While rstn=0, req_ready=0 and ena=enb=wea=0.
- A read granted in the cycle before reset asserts produces no response.
- A write whose edge coincides with reset assertion is not guaranteed.

## Structure
- Package bram_arb_pkg holds localparam helpers: AW, the one-hot-to-index function and the rotate helper.
- Sub-module rr_arbiter (parameter N) holds the request vector, the pointer register, the one-hot grant and the grant-valid output. It is instantiated twice, once for writes and once for reads.
- The top level holds the muxes, the response register and the bypass register.

## Test plan
- Single write then read: req0 writes 0xDEADBEEF to addr 5 and is acked in T. It reads addr 5 in T+1. Required: resp_valid[0] in T+2 with resp_data=0xDEADBEEF.
- Write contention: req0 and req1 both write continuously to addresses 1 and 2. Required: grants alternate 0,1,0,1 from reset. ena=1 every cycle. The BRAM holds both values.
- Parallel ports: req0 writes addr 3=0x11 while req1 reads addr 7 (preloaded 0x77) in the same cycle. Required: both ready=1. Next cycle resp_valid=2'b10 with resp_data=0x77.
- Collision bypass: req0 writes addr 9=0xABCD0123 while req1 reads addr 9 in the same cycle, with old content 0. Required: resp_data=0xABCD0123 with resp_valid[1] in the next cycle.
- Reset mid-operation: req1 read granted, then rstn pulses low before the next edge. Required: resp_valid=0 and resp_data=0 immediately. After release, the first grant goes to requester 0 when both request.
- Idle: no req_valid. Required: ena=enb=wea=0, resp_valid=0, and both pointers unchanged.
